// File: rtl/hazard_unit_if.sv
// Decode-side bundle between the ID stage and the hazard unit: ID decode fields in,
// stall/flush/forward controls out.
interface hazard_unit_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] rsD;
    logic [REG_AW-1:0] rtD;
    logic [REG_AW-1:0] writeRegD;
    logic              regWriteD;
    logic              memToRegD;
    logic              isBranchD;
    logic              memStallM;
    logic              stallF;
    logic              stallD;
    logic              flushE;
    logic              forwardAD;
    logic              forwardBD;
    logic [1:0]        forwardAE;
    logic [1:0]        forwardBE;

    modport master (
        output rsD, rtD, writeRegD, regWriteD, memToRegD, isBranchD, memStallM,
        input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE
    );

    modport slave (
        input  rsD, rtD, writeRegD, regWriteD, memToRegD, isBranchD, memStallM,
        output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE
    );
endinterface

// File: rtl/hazard_unit.sv
// Scoreboard hazard controller: shadows the register-use fields of EX/MEM/WB and derives
// stalls, the EX flush and all forwarding selects. HAZARD_PERF_CNT_EN adds the stallCnt counter.
module hazard_unit #(
    parameter int REG_AW = 5
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    hazard_unit_if.slave       hzIf
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stallCnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wreg;
        logic              regWrite;
        logic              memToReg;
    } shadowT;

    shadowT eReg;
    shadowT mReg;
    shadowT wReg;
    shadowT eNext;

    logic lwStall;
    logic brStall;
    logic hz;

    // A stage only counts as a producer for a real, nonzero destination.
    function automatic logic writesReg(input shadowT s, input logic [REG_AW-1:0] r);
        return s.valid && s.regWrite && (s.wreg != '0) && (s.wreg == r);
    endfunction

    always_comb begin
        lwStall = eReg.valid && eReg.memToReg &&
                  (writesReg(eReg, hzIf.rsD) || writesReg(eReg, hzIf.rtD));
        brStall = hzIf.isBranchD &&
                  (writesReg(eReg, hzIf.rsD) || writesReg(eReg, hzIf.rtD) ||
                   (mReg.memToReg && (writesReg(mReg, hzIf.rsD) || writesReg(mReg, hzIf.rtD))));
        hz      = lwStall || brStall;
    end

    always_comb begin
        eNext = '0;
        if (!hz) begin
            eNext.valid    = 1'b1;
            eNext.rs       = hzIf.rsD;
            eNext.rt       = hzIf.rtD;
            eNext.wreg     = hzIf.writeRegD;
            eNext.regWrite = hzIf.regWriteD;
            eNext.memToReg = hzIf.memToRegD;
        end
    end

    // The shadow pipe freezes with the real pipeline while data memory is busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eReg <= '0;
            mReg <= '0;
            wReg <= '0;
        end else if (!hzIf.memStallM) begin
            wReg <= mReg;
            mReg <= eReg;
            eReg <= eNext;
        end
    end

    logic [REG_AW-1:0] srcE [2];
    logic [REG_AW-1:0] srcD [2];
    logic [1:0]        fwdE [2];
    logic              fwdD [2];

    assign srcE[0] = eReg.rs;
    assign srcE[1] = eReg.rt;
    assign srcD[0] = hzIf.rsD;
    assign srcD[1] = hzIf.rtD;

    // M wins over W when both produce the same register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gFwd
            assign fwdE[gi] = writesReg(mReg, srcE[gi]) ? 2'b10 :
                              writesReg(wReg, srcE[gi]) ? 2'b01 : 2'b00;
            assign fwdD[gi] = writesReg(mReg, srcD[gi]) && !mReg.memToReg;
        end
    endgenerate

    // Outputs are gated by reset so they drop immediately, independent of clk.
    assign hzIf.stallF    = rst && (hzIf.memStallM || hz);
    assign hzIf.stallD    = rst && (hzIf.memStallM || hz);
    assign hzIf.flushE    = rst && !hzIf.memStallM && hz;
    assign hzIf.forwardAE = rst ? fwdE[0] : 2'b00;
    assign hzIf.forwardBE = rst ? fwdE[1] : 2'b00;
    assign hzIf.forwardAD = rst && fwdD[0];
    assign hzIf.forwardBD = rst && fwdD[1];

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCntReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCntReg <= '0;
        end else if (hz && !hzIf.memStallM && (stallCntReg != '1)) begin
            stallCntReg <= stallCntReg + 1'b1;
        end
    end

    assign stallCnt = stallCntReg;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: load-use, ALU forwarding, branch stalls, memory freeze,
// r0 handling and asynchronous reset; one line per checked transaction.
module tb_hazard_unit;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [8:0] outVec;

    hazard_unit_if #(.REG_AW(5)) hzIf ();

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stallCnt;
    hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .hzIf     (hzIf.slave),
        .stallCnt (stallCnt)
    );
`else
    hazard_unit #(.REG_AW(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .hzIf (hzIf.slave)
    );
`endif

    // {stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE}
    assign outVec = {hzIf.stallF, hzIf.stallD, hzIf.flushE, hzIf.forwardAD,
                     hzIf.forwardBD, hzIf.forwardAE, hzIf.forwardBE};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                         input logic rw, input logic ml, input logic br, input logic ms);
        hzIf.rsD       = rs;
        hzIf.rtD       = rt;
        hzIf.writeRegD = wr;
        hzIf.regWriteD = rw;
        hzIf.memToRegD = ml;
        hzIf.isBranchD = br;
        hzIf.memStallM = ms;
    endtask

    task automatic randomInputs();
        drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic expectOut(input string tag, input logic [8:0] exp);
        @(negedge clk);
        chk(tag, 32'(outVec), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // Reset from time zero with arbitrary inputs, before any clock edge
        rst = 1'b0;
        randomInputs();
        #3;
        chk("rst_async", 32'(outVec), 32'h0);
        hzIf.memStallM = 1'b1;
        #1;
        chk("rst_memstall", 32'(outVec), 32'h0);
        tick();
        chk("rst_clocked", 32'(outVec), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_cnt", 32'(stallCnt), 32'h0);
`endif
        rst = 1'b1;
        drain();

        // Load r5 then dependent add: one stall, then WB forward
        drive(1, 0, 5, 1, 1, 0, 0);  expectOut("ld_issue",   9'b000_00_00_00); tick();
        drive(5, 6, 8, 1, 0, 0, 0);  expectOut("ld_use_stl", 9'b111_00_00_00); tick();
                                     expectOut("ld_use_go",  9'b000_00_00_00); tick();
        drive(0, 0, 0, 0, 0, 0, 0);  expectOut("ld_use_fwd", 9'b000_00_01_00); tick();
        drain();

        // add r3; sub rt=3; or rs=3: MEM then WB forwarding, no stalls
        drive(1, 2, 3, 1, 0, 0, 0);  expectOut("add_r3",     9'b000_00_00_00); tick();
        drive(4, 3, 9, 1, 0, 0, 0);  expectOut("sub_id",     9'b000_00_00_00); tick();
        drive(3, 4, 10, 1, 0, 0, 0); expectOut("sub_fwdBE",  9'b000_10_00_10); tick();
        drive(0, 0, 0, 0, 0, 0, 0);  expectOut("or_fwdAE",   9'b000_00_01_00); tick();
        drain();

        // add r7 then beq rs=7: one stall, then forwardAD
        drive(1, 2, 7, 1, 0, 0, 0);  expectOut("add_r7",     9'b000_00_00_00); tick();
        drive(7, 8, 0, 0, 0, 1, 0);  expectOut("br_alu_stl", 9'b111_00_00_00); tick();
                                     expectOut("br_alu_fAD", 9'b000_10_00_00); tick();
        drive(0, 0, 0, 0, 0, 0, 0);  expectOut("br_alu_ex",  9'b000_00_01_00); tick();
        drain();

        // Load r7 then beq rs=7: two stalls, never forwardAD
        drive(1, 0, 7, 1, 1, 0, 0);  expectOut("ld_r7",      9'b000_00_00_00); tick();
        drive(7, 8, 0, 0, 0, 1, 0);  expectOut("br_ld_stl1", 9'b111_00_00_00); tick();
                                     expectOut("br_ld_stl2", 9'b111_00_00_00); tick();
                                     expectOut("br_ld_go",   9'b000_00_00_00); tick();
        drain();
`ifdef HAZARD_PERF_CNT_EN
        chk("cnt_after4", 32'(stallCnt), 32'd4);
`endif

        // Reset asserted in the middle of a load-use stall
        drive(1, 0, 5, 1, 1, 0, 0);  expectOut("pre_rst_ld", 9'b000_00_00_00); tick();
        drive(5, 6, 8, 1, 0, 0, 0);  expectOut("pre_rst_stl", 9'b111_00_00_00);
        #2;
        rst = 1'b0;
        randomInputs();
        #1;
        chk("midrst_async", 32'(outVec), 32'h0);
        expectOut("midrst_held", 9'b000_00_00_00);
`ifdef HAZARD_PERF_CNT_EN
        chk("midrst_cnt", 32'(stallCnt), 32'h0);
`endif
        tick();
        rst = 1'b1;
        drive(5, 6, 8, 1, 0, 0, 0);  expectOut("post_rst_clr", 9'b000_00_00_00); tick();

        // Load r5, dependent add, memory freeze for 3 cycles during the stall
        drive(1, 0, 5, 1, 1, 0, 0);  expectOut("frz_ld",     9'b000_00_00_00); tick();
        for (int i = 0; i < 3; i++) begin
            drive(5, 6, 8, 1, 0, 0, 1);
            expectOut($sformatf("frz_hold%0d", i), 9'b110_00_00_00);
            tick();
        end
        drive(5, 6, 8, 1, 0, 0, 0);  expectOut("frz_stall",  9'b111_00_00_00); tick();
                                     expectOut("frz_go",     9'b000_00_00_00); tick();
        drive(0, 0, 0, 0, 0, 0, 0);  expectOut("frz_fwd",    9'b000_00_01_00);
`ifdef HAZARD_PERF_CNT_EN
        chk("frz_cnt", 32'(stallCnt), 32'd1);
`endif
        tick();
        drain();

        // Writes to r0 never stall or forward
        drive(1, 2, 0, 1, 1, 0, 0);  expectOut("r0_ld",      9'b000_00_00_00); tick();
        drive(0, 0, 0, 1, 0, 1, 0);  expectOut("r0_br",      9'b000_00_00_00); tick();
        drive(0, 0, 0, 0, 0, 0, 0);  expectOut("r0_ex",      9'b000_00_00_00); tick();
                                     expectOut("r0_wb",      9'b000_00_00_00); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
